// File: rtl/lsu_ctrl_pkg.sv
// Shared types for the memory-stage load/store sequencer: decoded ops, state,
// bus size codes and store lane helpers.
package lsu_ctrl_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW
    } decoded_op_t;

    typedef enum logic [1:0] {
        ST_IDLE, ST_REQ, ST_WAIT, ST_RESP
    } lsu_state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    function automatic logic [1:0] op_size(decoded_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_B;
            OP_LH, OP_LHU, OP_SH: return SZ_H;
            default:              return SZ_W;
        endcase
    endfunction

    function automatic logic op_is_store(decoded_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Narrow stores are replicated so every lane the strobe selects carries the data.
    function automatic word_t store_data(decoded_op_t op, word_t wdata);
        case (op_size(op))
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(decoded_op_t op, logic [1:0] offset);
        if (!op_is_store(op)) return 4'b0000;
        case (op_size(op))
            SZ_B:    return 4'b0001 << offset;
            SZ_H:    return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_load_align.sv
// Moves the addressed byte/half of a raw bus word down to bit 0 and extends it
// according to the load op; stores produce zero.
module lsu_ctrl_load_align
    import lsu_ctrl_pkg::*;
(
    input  word_t       rdata,
    input  logic [1:0]  offset,
    input  decoded_op_t op,
    output word_t       result
);

    word_t shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (op)
            OP_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  result = {24'd0, shifted[7:0]};
            OP_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  result = {16'd0, shifted[15:0]};
            OP_LW:   result = shifted;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Memory-stage load/store sequencer: one outstanding transaction on the
// SRAM-like data bus, stalls the pipeline until the aligned result is back.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_i,
    input  decoded_op_t op_i,
    input  word_t       addr_i,
    input  word_t       wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output word_t       rdata_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output word_t       data_addr,
    output word_t       data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  word_t       data_rdata,
    output lsu_state_t  state_dbg
);

    // Handshakes: the stage holds valid_i/op_i/addr_i while stall_o is high and an op
    // is taken in IDLE in the cycle stall_o rises with it; data_req and all bus outputs
    // stay constant until the cycle data_addr_ok is seen; data_data_ok is a one-cycle
    // response that is always consumed in WAIT.
    lsu_state_t  state;
    decoded_op_t op_q;
    logic        kill;
    logic        misaligned;
    logic        accept;
    word_t       aligned;

    always_comb begin
        case (op_size(op_i))
            SZ_H:    misaligned = addr_i[0];
            SZ_W:    misaligned = |addr_i[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign accept  = (state == ST_IDLE) && valid_i && !flush_i && !misaligned;
    assign adel_o  = (state == ST_IDLE) && valid_i && misaligned && !op_is_store(op_i);
    assign ades_o  = (state == ST_IDLE) && valid_i && misaligned && op_is_store(op_i);
    assign stall_o = accept || (state == ST_REQ) || (state == ST_WAIT);
    assign state_dbg = state;

    lsu_ctrl_load_align u_load_align (
        .rdata  (data_rdata),
        .offset (data_addr[1:0]),
        .op     (op_q),
        .result (aligned)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            op_q       <= OP_LB;
            kill       <= 1'b0;
            done_o     <= 1'b0;
            rdata_o    <= '0;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= SZ_B;
            data_addr  <= '0;
            data_wdata <= '0;
            data_wstrb <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    kill <= 1'b0;
                    if (accept) begin
                        op_q       <= op_i;
                        data_addr  <= addr_i;
                        data_size  <= op_size(op_i);
                        data_wr    <= op_is_store(op_i);
                        data_wdata <= store_data(op_i, wdata_i);
                        data_wstrb <= store_strb(op_i, addr_i[1:0]);
                        data_req   <= 1'b1;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (flush_i) kill <= 1'b1;
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (data_data_ok) begin
                        kill <= 1'b0;
                        // A flush arriving with the response still suppresses it.
                        if (kill || flush_i) begin
                            state <= ST_IDLE;
                        end else begin
                            rdata_o <= aligned;
                            done_o  <= 1'b1;
                            state   <= ST_RESP;
                        end
                    end else if (flush_i) begin
                        kill <= 1'b1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed and random load/store ops against a scheduled bus
// responder and an arithmetic reference model of alignment and lane placement.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid_i;
    decoded_op_t op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        adel_o;
    logic        ades_o;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    lsu_state_t  state_dbg;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    lsu_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .valid_i      (valid_i),
        .op_i         (op_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .adel_o       (adel_o),
        .ades_o       (ades_o),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    // Reference model: byte counts, lane arithmetic and sign extension by subtraction.
    function automatic int op_bytes(decoded_op_t op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic bit is_store(decoded_op_t op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic logic [31:0] ref_load(decoded_op_t op, logic [31:0] addr, logic [31:0] w);
        logic [31:0] s;
        logic [31:0] b;
        logic [31:0] h;
        s = w >> (8 * (addr % 4));
        b = s & 32'hFF;
        h = s & 32'hFFFF;
        case (op)
            OP_LB:   return (b >= 32'h80) ? b - 32'h100 : b;
            OP_LBU:  return b;
            OP_LH:   return (h >= 32'h8000) ? h - 32'h10000 : h;
            OP_LHU:  return h;
            OP_LW:   return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(decoded_op_t op, logic [31:0] w);
        if (op_bytes(op) == 1) return (w & 32'hFF) * 32'h01010101;
        if (op_bytes(op) == 2) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    // Drives one aligned op from accept to completion; addr_ok comes n_addr cycles into
    // REQ, data_ok n_data cycles into WAIT, flush_i is pulsed in cycle fc (-1 = never).
    task automatic run_op(input decoded_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rword, input int n_addr, input int n_data, input int fc);
        int dok;
        bit killed;
        bit in_req;
        logic [1:0] exp_size;
        logic [3:0] exp_strb;
        logic [31:0] exp_rd;
        dok = 2 + n_addr + n_data;
        killed = (fc >= 1) && (fc <= dok);
        exp_size = (op_bytes(op) == 1) ? 2'd0 : (op_bytes(op) == 2) ? 2'd1 : 2'd2;
        exp_strb = is_store(op) ? 4'(((1 << op_bytes(op)) - 1) << (addr % 4)) : 4'b0000;
        if (!killed) exp_q.push_back(ref_load(op, addr, rword));
        valid_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wdata; data_rdata = rword;
        for (int cyc = 0; cyc <= dok + 1; cyc++) begin
            if (killed && cyc > fc) valid_i = 1'b0;
            flush_i      = (cyc == fc);
            data_addr_ok = (cyc == 1 + n_addr);
            data_data_ok = (cyc == dok);
            @(negedge clk);
            in_req = (cyc >= 1) && (cyc <= 1 + n_addr);
            total++;
            if (stall_o !== (cyc <= dok)) begin
                bad++; $display("FAIL stall op=%s cyc=%0d got=%b want=%b", op.name(), cyc, stall_o, cyc <= dok);
            end
            total++;
            if (done_o !== (cyc == dok + 1 && !killed)) begin
                bad++; $display("FAIL done op=%s cyc=%0d got=%b want=%b", op.name(), cyc, done_o, cyc == dok + 1 && !killed);
            end
            total++;
            if (data_req !== in_req) begin
                bad++; $display("FAIL req op=%s cyc=%0d got=%b want=%b", op.name(), cyc, data_req, in_req);
            end
            if (in_req) begin
                total++;
                if ({data_addr, data_wr, data_size, data_wstrb} !== {addr, is_store(op), exp_size, exp_strb}) begin
                    bad++; $display("FAIL bus_ctl op=%s cyc=%0d got=%h/%b/%0d/%b want=%h/%b/%0d/%b", op.name(), cyc,
                                    data_addr, data_wr, data_size, data_wstrb, addr, is_store(op), exp_size, exp_strb);
                end
                if (is_store(op)) begin
                    total++;
                    if (data_wdata !== ref_wdata(op, wdata)) begin
                        bad++; $display("FAIL bus_wdata op=%s got=%h want=%h", op.name(), data_wdata, ref_wdata(op, wdata));
                    end
                end
            end
            if (cyc == dok + 1 && !killed && exp_q.size() > 0) begin
                exp_rd = exp_q.pop_front();
                total++;
                if (rdata_o !== exp_rd) begin
                    bad++; $display("FAIL rdata op=%s addr=%h got=%h want=%h", op.name(), addr, rdata_o, exp_rd);
                end
            end
            @(posedge clk); #1;
        end
        valid_i = 1'b0; flush_i = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    endtask

    task automatic test_misaligned(input decoded_op_t op, input logic [31:0] addr);
        valid_i = 1'b1; op_i = op; addr_i = addr; wdata_i = $urandom;
        for (int cyc = 0; cyc < 2; cyc++) begin
            @(negedge clk);
            total++;
            if ({adel_o, ades_o, stall_o} !== {!is_store(op), is_store(op), 1'b0}) begin
                bad++; $display("FAIL misalign_flags op=%s addr=%h got=%b%b%b want=%b%b0", op.name(), addr,
                                adel_o, ades_o, stall_o, !is_store(op), is_store(op));
            end
            total++;
            if (data_req !== 1'b0) begin
                bad++; $display("FAIL misalign_req op=%s got=%b want=0", op.name(), data_req);
            end
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0; valid_i = 1'b0; op_i = OP_LB; addr_i = '0; wdata_i = '0; flush_i = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        #12;
        total++;
        if ({stall_o, done_o, rdata_o, adel_o, ades_o, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb} !== 108'd0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", {stall_o, done_o, rdata_o, adel_o, ades_o, data_req,
                            data_wr, data_size, data_addr, data_wdata, data_wstrb});
        end
        total++;
        if (state_dbg !== ST_IDLE) begin
            bad++; $display("FAIL reset_state got=%s want=ST_IDLE", state_dbg.name());
        end
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        run_op(OP_LB,  32'h103, 32'h0, 32'h80FF_1234, 0, 0, -1);
        run_op(OP_LBU, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, -1);
        run_op(OP_SH,  32'h202, 32'h0000_ABCD, 32'h0, 0, 0, -1);
        run_op(OP_LW,  32'h400, 32'h0, 32'hDEAD_BEEF, 2, 2, -1);
        run_op(OP_LH,  32'h302, 32'h0, 32'h8001_7FFF, 1, 0, -1);
        run_op(OP_SB,  32'h001, 32'h0000_005A, 32'h0, 0, 1, -1);
    endtask

    task automatic test_flush;
        run_op(OP_LW, 32'h700, 32'h0, 32'h1111_2222, 0, 2, 3);
        run_op(OP_LW, 32'h704, 32'h0, 32'h3333_4444, 1, 1, 4);
        run_op(OP_LB, 32'h708, 32'h0, 32'h5555_6666, 2, 0, 1);
        run_op(OP_LHU, 32'h70A, 32'h0, 32'h7777_8888, 0, 0, -1);
        valid_i = 1'b1; flush_i = 1'b1; op_i = OP_LW; addr_i = 32'h800;
        @(negedge clk);
        total++;
        if (stall_o !== 1'b0) begin
            bad++; $display("FAIL flush_accept_stall got=%b want=0", stall_o);
        end
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        total++;
        if (data_req !== 1'b0) begin
            bad++; $display("FAIL flush_accept_req got=%b want=0", data_req);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset;
        valid_i = 1'b1; op_i = OP_LW; addr_i = 32'h500; wdata_i = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(negedge clk);
        total++;
        if (data_req !== 1'b1) begin
            bad++; $display("FAIL pre_reset_req got=%b want=1", data_req);
        end
        #1 resetn = 1'b0;
        #1;
        total++;
        if ({stall_o, done_o, rdata_o, adel_o, ades_o, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb} !== 108'd0) begin
            bad++; $display("FAIL async_reset_outputs got=%h want=0", {stall_o, done_o, rdata_o, adel_o, ades_o, data_req,
                            data_wr, data_size, data_addr, data_wdata, data_wstrb});
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        run_op(OP_LW, 32'h600, 32'h0, 32'hCAFE_F00D, 0, 0, -1);
    endtask

    task automatic test_random;
        decoded_op_t op;
        int bytes;
        int na;
        int nd;
        int fc;
        logic [31:0] addr;
        for (int i = 0; i < 40; i++) begin
            op = decoded_op_t'($urandom_range(0, 7));
            bytes = op_bytes(op);
            addr = $urandom;
            if (bytes > 1 && $urandom_range(0, 4) == 0) begin
                addr[1:0] = (bytes == 2) ? ($urandom_range(0, 1) ? 2'd1 : 2'd3) : 2'($urandom_range(1, 3));
                test_misaligned(op, addr);
            end else begin
                addr = addr & ~(32'(bytes) - 32'd1);
                na = $urandom_range(0, 3);
                nd = $urandom_range(0, 3);
                fc = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2 + na + nd) : -1;
                run_op(op, addr, $urandom, $urandom, na, nd, fc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_misaligned(OP_LH, 32'h301);
        test_misaligned(OP_SW, 32'h302);
        test_flush();
        test_async_reset();
        test_random();
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
